// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and its consumer (slave).
// The tile coordinate signals exist only when VGA_TILE_EN is defined.
interface vga_timing_gen_if #(
    parameter int CW = 12
`ifdef VGA_TILE_EN
    ,
    parameter int TILE_SHIFT = 5
`endif
);
    logic          en;
    logic          pix_en;
    logic          lcd_hs;
    logic          lcd_vs;
    logic          lcd_de;
    logic [CW-1:0] lcd_x;
    logic [CW-1:0] lcd_y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TILE_EN
    logic [CW-1:0]         tile_col;
    logic [CW-1:0]         tile_row;
    logic [TILE_SHIFT-1:0] tile_px;
    logic [TILE_SHIFT-1:0] tile_py;

    modport master (
        input  en,
        output pix_en, lcd_hs, lcd_vs, lcd_de, lcd_x, lcd_y, line_start, frame_start,
        output tile_col, tile_row, tile_px, tile_py
    );
    modport slave (
        output en,
        input  pix_en, lcd_hs, lcd_vs, lcd_de, lcd_x, lcd_y, line_start, frame_start,
        input  tile_col, tile_row, tile_px, tile_py
    );
`else
    modport master (
        input  en,
        output pix_en, lcd_hs, lcd_vs, lcd_de, lcd_x, lcd_y, line_start, frame_start
    );
    modport slave (
        output en,
        input  pix_en, lcd_hs, lcd_vs, lcd_de, lcd_x, lcd_y, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; outputs trail the counters by one pixel tick, en low freezes everything.
// Define VGA_TILE_EN to add registered tile index/offset outputs aligned with lcd_de.
module vga_timing_gen #(
    parameter int H_DISP     = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISP     = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CLK_DIV    = 2,
    parameter int CW         = 12,
    parameter int TILE_SHIFT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_LO   = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT_HI   = CW'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [CW-1:0] V_ACT_LO   = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT_HI   = CW'(V_SYNC + V_BACK + V_DISP - 1);
    localparam logic [3:0]    DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic          HS_ON      = 1'(HS_POL);
    localparam logic          VS_ON      = 1'(VS_POL);

    if (H_TOTAL > (1 << CW) - 1 || V_TOTAL > (1 << CW) - 1) begin : g_size_err
        $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (TILE_SHIFT < 1 || TILE_SHIFT >= CW) begin : g_tile_err
        $error("vga_timing_gen: TILE_SHIFT must be 1..CW-1");
    end

    logic [3:0]    div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          lcd_hs_q, lcd_hs_d;
    logic          lcd_vs_q, lcd_vs_d;
    logic          lcd_de_q, lcd_de_d;
    logic [CW-1:0] lcd_x_q, lcd_x_d;
    logic [CW-1:0] lcd_y_q, lcd_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          h_act, v_act, act;
    logic [CW-1:0] x_dec, y_dec;

    // A tick already queued when en drops is discarded, so the raster holds exactly.
    assign tick = pix_en_q & vif.en;

    always_comb begin
        div_d    = div_q;
        pix_en_d = 1'b0;
        if (vif.en) begin
            pix_en_d = (div_q == DIV_LAST);
            div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end
    end

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_act = (hcnt_q >= H_ACT_LO) && (hcnt_q <= H_ACT_HI);
        v_act = (vcnt_q >= V_ACT_LO) && (vcnt_q <= V_ACT_HI);
        act   = h_act && v_act;
        x_dec = act ? hcnt_q - H_ACT_LO : '0;
        y_dec = act ? vcnt_q - V_ACT_LO : '0;
    end

    // Output stage decodes the pre-advance position, keeping all outputs aligned.
    always_comb begin
        lcd_hs_d      = lcd_hs_q;
        lcd_vs_d      = lcd_vs_q;
        lcd_de_d      = lcd_de_q;
        lcd_x_d       = lcd_x_q;
        lcd_y_d       = lcd_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            lcd_hs_d      = (hcnt_q < H_SYNC_END) ? HS_ON : ~HS_ON;
            lcd_vs_d      = (vcnt_q < V_SYNC_END) ? VS_ON : ~VS_ON;
            lcd_de_d      = act;
            lcd_x_d       = x_dec;
            lcd_y_d       = y_dec;
            line_start_d  = (hcnt_q == '0);
            frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            lcd_hs_q      <= ~HS_ON;
            lcd_vs_q      <= ~VS_ON;
            lcd_de_q      <= 1'b0;
            lcd_x_q       <= '0;
            lcd_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            lcd_hs_q      <= lcd_hs_d;
            lcd_vs_q      <= lcd_vs_d;
            lcd_de_q      <= lcd_de_d;
            lcd_x_q       <= lcd_x_d;
            lcd_y_q       <= lcd_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.pix_en      = pix_en_q & vif.en;
    assign vif.lcd_hs      = lcd_hs_q;
    assign vif.lcd_vs      = lcd_vs_q;
    assign vif.lcd_de      = lcd_de_q;
    assign vif.lcd_x       = lcd_x_q;
    assign vif.lcd_y       = lcd_y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

`ifdef VGA_TILE_EN
    logic [CW-1:0]         tile_col_q, tile_col_d;
    logic [CW-1:0]         tile_row_q, tile_row_d;
    logic [TILE_SHIFT-1:0] tile_px_q, tile_px_d;
    logic [TILE_SHIFT-1:0] tile_py_q, tile_py_d;

    // x_dec/y_dec are already zero outside the window, so the tile fields follow.
    always_comb begin
        tile_col_d = tile_col_q;
        tile_row_d = tile_row_q;
        tile_px_d  = tile_px_q;
        tile_py_d  = tile_py_q;
        if (tick) begin
            tile_col_d = x_dec >> TILE_SHIFT;
            tile_row_d = y_dec >> TILE_SHIFT;
            tile_px_d  = x_dec[TILE_SHIFT-1:0];
            tile_py_d  = y_dec[TILE_SHIFT-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tile_col_q <= '0;
            tile_row_q <= '0;
            tile_px_q  <= '0;
            tile_py_q  <= '0;
        end else begin
            tile_col_q <= tile_col_d;
            tile_row_q <= tile_row_d;
            tile_px_q  <= tile_px_d;
            tile_py_q  <= tile_py_d;
        end
    end

    assign vif.tile_col = tile_col_q;
    assign vif.tile_row = tile_row_q;
    assign vif.tile_px  = tile_px_q;
    assign vif.tile_py  = tile_py_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode (two dividers), a tiny mode, inverted polarity and optional tiles.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic rst_d = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    vga_timing_gen_if #(.CW(12)) if_a ();
    vga_timing_gen_if #(.CW(12)) if_b ();
    vga_timing_gen_if #(.CW(12)) if_c ();
    vga_timing_gen_if #(.CW(12)) if_d ();

    vga_timing_gen #(.CLK_DIV(2)) u_a (.clk(clk), .rst_n(rst_a), .vif(if_a));
    vga_timing_gen #(.CLK_DIV(1)) u_b (.clk(clk), .rst_n(rst_b), .vif(if_b));
    vga_timing_gen #(
        .H_DISP(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISP(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
    ) u_c (.clk(clk), .rst_n(rst_c), .vif(if_c));
    vga_timing_gen #(
        .H_DISP(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISP(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(3)
    ) u_d (.clk(clk), .rst_n(rst_d), .vif(if_d));

`ifdef VGA_TILE_EN
    logic rst_t = 1'b1;
    vga_timing_gen_if #(.CW(12), .TILE_SHIFT(5)) if_t ();
    vga_timing_gen #(
        .H_DISP(100), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISP(40), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .TILE_SHIFT(5)
    ) u_t (.clk(clk), .rst_n(rst_t), .vif(if_t));
`endif

    task automatic test_reset();
        rst_a = 1'b1;
        if_a.en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (if_a.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs: got %b want 1", if_a.lcd_hs); end
        n_cmp++; if (if_a.lcd_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs: got %b want 1", if_a.lcd_vs); end
        n_cmp++; if (if_a.lcd_de !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %b want 0", if_a.lcd_de); end
        n_cmp++; if (if_a.lcd_x !== 12'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", if_a.lcd_x); end
        n_cmp++; if (if_a.lcd_y !== 12'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", if_a.lcd_y); end
        n_cmp++; if (if_a.pix_en !== 1'b0) begin n_bad++; $display("FAIL reset_pix_en: got %b want 0", if_a.pix_en); end
        n_cmp++; if (if_a.line_start !== 1'b0) begin n_bad++; $display("FAIL reset_ls: got %b want 0", if_a.line_start); end
        n_cmp++; if (if_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", if_a.frame_start); end
        rst_a = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_a.pix_en !== 1'b0) begin n_bad++; $display("FAIL rel1_pix_en: got %b want 0", if_a.pix_en); end
        @(negedge clk);
        n_cmp++; if (if_a.pix_en !== 1'b1) begin n_bad++; $display("FAIL rel2_pix_en: got %b want 1", if_a.pix_en); end
        n_cmp++; if (if_a.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL rel2_hs: got %b want 1", if_a.lcd_hs); end
        @(negedge clk);
        n_cmp++; if (if_a.pix_en !== 1'b0) begin n_bad++; $display("FAIL tick1_pix_en: got %b want 0", if_a.pix_en); end
        n_cmp++; if (if_a.lcd_hs !== 1'b0) begin n_bad++; $display("FAIL tick1_hs: got %b want 0", if_a.lcd_hs); end
        n_cmp++; if (if_a.lcd_vs !== 1'b0) begin n_bad++; $display("FAIL tick1_vs: got %b want 0", if_a.lcd_vs); end
        n_cmp++; if (if_a.frame_start !== 1'b1) begin n_bad++; $display("FAIL tick1_fs: got %b want 1", if_a.frame_start); end
        n_cmp++; if (if_a.line_start !== 1'b1) begin n_bad++; $display("FAIL tick1_ls: got %b want 1", if_a.line_start); end
        @(negedge clk);
        n_cmp++; if (if_a.frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_width: got %b want 0", if_a.frame_start); end
        n_cmp++; if (if_a.pix_en !== 1'b1) begin n_bad++; $display("FAIL rel4_pix_en: got %b want 1", if_a.pix_en); end
        @(negedge clk);
        n_cmp++; if (if_a.line_start !== 1'b0) begin n_bad++; $display("FAIL tick2_ls: got %b want 0", if_a.line_start); end
        n_cmp++; if (if_a.lcd_hs !== 1'b0) begin n_bad++; $display("FAIL tick2_hs: got %b want 0", if_a.lcd_hs); end
    endtask

    task automatic test_en_freeze();
        int cnt;
        bit found;
        rst_a = 1'b1;
        if_a.en = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000 && cnt < 100; i++) begin
            @(negedge clk);
            if (if_a.pix_en === 1'b1) cnt++;
        end
        n_cmp++; if (cnt !== 100) begin n_bad++; $display("FAIL freeze_reach: got %0d ticks want 100", cnt); end
        @(negedge clk);
        if_a.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (if_a.pix_en !== 1'b0) begin n_bad++; $display("FAIL freeze_pix_en[%0d]: got %b want 0", i, if_a.pix_en); end
        end
        n_cmp++; if (if_a.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL freeze_hs: got %b want 1", if_a.lcd_hs); end
        n_cmp++; if (if_a.lcd_vs !== 1'b0) begin n_bad++; $display("FAIL freeze_vs: got %b want 0", if_a.lcd_vs); end
        if_a.en = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (if_a.pix_en === 1'b1) cnt++;
            if (if_a.line_start === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL resume_ls_seen: got %b want 1", found); end
        n_cmp++; if (cnt !== 701) begin n_bad++; $display("FAIL resume_ticks_to_ls: got %0d want 701", cnt); end
    endtask

    task automatic test_reset_mid();
        #2 rst_a = 1'b1;
        #1;
        n_cmp++; if (if_a.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL mid_rst_hs: got %b want 1", if_a.lcd_hs); end
        n_cmp++; if (if_a.lcd_vs !== 1'b1) begin n_bad++; $display("FAIL mid_rst_vs: got %b want 1", if_a.lcd_vs); end
        n_cmp++; if (if_a.line_start !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ls: got %b want 0", if_a.line_start); end
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (if_a.frame_start !== 1'b1) begin n_bad++; $display("FAIL mid_rel_fs: got %b want 1", if_a.frame_start); end
        n_cmp++; if (if_a.lcd_hs !== 1'b0) begin n_bad++; $display("FAIL mid_rel_hs: got %b want 0", if_a.lcd_hs); end
    endtask

    task automatic test_small_mode();
        int exp_x [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int exp_y [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        int got_x [12];
        int got_y [12];
        int fs_tick [2];
        int n_hs, n_vs, n_de, n_ls, n_fs, first_de, last_de, bad_zero, pix_low;
        n_hs = 0; n_vs = 0; n_de = 0; n_ls = 0; n_fs = 0;
        first_de = -1; last_de = -1; bad_zero = 0; pix_low = 0;
        fs_tick[0] = -1; fs_tick[1] = -1;
        for (int k = 0; k < 12; k++) begin got_x[k] = -1; got_y[k] = -1; end
        rst_c = 1'b1;
        if_c.en = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_c.pix_en !== 1'b1) begin n_bad++; $display("FAIL small_first_pix_en: got %b want 1", if_c.pix_en); end
        for (int s = 0; s < 56; s++) begin
            @(negedge clk);
            if (if_c.pix_en !== 1'b1) pix_low++;
            if (if_c.frame_start === 1'b1 && n_fs < 2) begin fs_tick[n_fs] = s; n_fs++; end
            if (s < 48) begin
                if (if_c.lcd_hs === 1'b0) n_hs++;
                if (if_c.lcd_vs === 1'b0) n_vs++;
                if (if_c.line_start === 1'b1) n_ls++;
                if (if_c.lcd_de === 1'b1) begin
                    if (n_de < 12) begin got_x[n_de] = int'(if_c.lcd_x); got_y[n_de] = int'(if_c.lcd_y); end
                    if (first_de < 0) first_de = s;
                    last_de = s;
                    n_de++;
                end else if (if_c.lcd_x !== 12'd0 || if_c.lcd_y !== 12'd0) begin
                    bad_zero++;
                end
            end
        end
        n_cmp++; if (n_hs !== 12) begin n_bad++; $display("FAIL small_hs_low: got %0d want 12", n_hs); end
        n_cmp++; if (n_vs !== 8) begin n_bad++; $display("FAIL small_vs_low: got %0d want 8", n_vs); end
        n_cmp++; if (n_de !== 12) begin n_bad++; $display("FAIL small_de_count: got %0d want 12", n_de); end
        n_cmp++; if (n_ls !== 6) begin n_bad++; $display("FAIL small_ls_count: got %0d want 6", n_ls); end
        n_cmp++; if (first_de !== 19) begin n_bad++; $display("FAIL small_first_de: got %0d want 19", first_de); end
        n_cmp++; if (last_de !== 38) begin n_bad++; $display("FAIL small_last_de: got %0d want 38", last_de); end
        n_cmp++; if (fs_tick[0] !== 0) begin n_bad++; $display("FAIL small_fs0: got %0d want 0", fs_tick[0]); end
        n_cmp++; if (fs_tick[1] !== 48) begin n_bad++; $display("FAIL small_fs1: got %0d want 48", fs_tick[1]); end
        n_cmp++; if (bad_zero !== 0) begin n_bad++; $display("FAIL small_xy_zero: got %0d nonzero want 0", bad_zero); end
        n_cmp++; if (pix_low !== 0) begin n_bad++; $display("FAIL small_pix_en_low: got %0d want 0", pix_low); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (got_x[k] !== exp_x[k]) begin n_bad++; $display("FAIL small_x[%0d]: got %0d want %0d", k, got_x[k], exp_x[k]); end
            n_cmp++; if (got_y[k] !== exp_y[k]) begin n_bad++; $display("FAIL small_y[%0d]: got %0d want %0d", k, got_y[k], exp_y[k]); end
        end
    endtask

    task automatic test_polarity();
        rst_d = 1'b1;
        if_d.en = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (if_d.lcd_hs !== 1'b0) begin n_bad++; $display("FAIL pol_reset_hs: got %b want 0", if_d.lcd_hs); end
        n_cmp++; if (if_d.lcd_vs !== 1'b0) begin n_bad++; $display("FAIL pol_reset_vs: got %b want 0", if_d.lcd_vs); end
        rst_d = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            case (n)
                2: begin
                    n_cmp++; if (if_d.pix_en !== 1'b0) begin n_bad++; $display("FAIL pol_n2_pix_en: got %b want 0", if_d.pix_en); end
                end
                3: begin
                    n_cmp++; if (if_d.pix_en !== 1'b1) begin n_bad++; $display("FAIL pol_n3_pix_en: got %b want 1", if_d.pix_en); end
                end
                4: begin
                    n_cmp++; if (if_d.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL pol_n4_hs: got %b want 1", if_d.lcd_hs); end
                    n_cmp++; if (if_d.lcd_vs !== 1'b1) begin n_bad++; $display("FAIL pol_n4_vs: got %b want 1", if_d.lcd_vs); end
                    n_cmp++; if (if_d.frame_start !== 1'b1) begin n_bad++; $display("FAIL pol_n4_fs: got %b want 1", if_d.frame_start); end
                end
                5: begin
                    n_cmp++; if (if_d.frame_start !== 1'b0) begin n_bad++; $display("FAIL pol_n5_fs: got %b want 0", if_d.frame_start); end
                    n_cmp++; if (if_d.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL pol_n5_hs: got %b want 1", if_d.lcd_hs); end
                end
                6: begin
                    n_cmp++; if (if_d.pix_en !== 1'b1) begin n_bad++; $display("FAIL pol_n6_pix_en: got %b want 1", if_d.pix_en); end
                end
                10: begin
                    n_cmp++; if (if_d.lcd_hs !== 1'b0) begin n_bad++; $display("FAIL pol_n10_hs: got %b want 0", if_d.lcd_hs); end
                    n_cmp++; if (if_d.lcd_vs !== 1'b1) begin n_bad++; $display("FAIL pol_n10_vs: got %b want 1", if_d.lcd_vs); end
                end
                25: begin
                    n_cmp++; if (if_d.lcd_vs !== 1'b1) begin n_bad++; $display("FAIL pol_n25_vs: got %b want 1", if_d.lcd_vs); end
                end
                28: begin
                    n_cmp++; if (if_d.lcd_hs !== 1'b1) begin n_bad++; $display("FAIL pol_n28_hs: got %b want 1", if_d.lcd_hs); end
                    n_cmp++; if (if_d.lcd_vs !== 1'b0) begin n_bad++; $display("FAIL pol_n28_vs: got %b want 0", if_d.lcd_vs); end
                    n_cmp++; if (if_d.line_start !== 1'b1) begin n_bad++; $display("FAIL pol_n28_ls: got %b want 1", if_d.line_start); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_default_mode();
        int n_ls, ls2, n_de, first_de, first_x, first_y, last_de, last_x, n_fs, n_hs, bad_zero;
        n_ls = 0; ls2 = -1; n_de = 0; first_de = -1; first_x = -1; first_y = -1;
        last_de = -1; last_x = -1; n_fs = 0; n_hs = 0; bad_zero = 0;
        rst_b = 1'b1;
        if_b.en = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 28800; s++) begin
            @(negedge clk);
            if (if_b.line_start === 1'b1) begin
                if (n_ls == 1) ls2 = s;
                n_ls++;
            end
            if (if_b.frame_start === 1'b1) n_fs++;
            if (s < 800 && if_b.lcd_hs === 1'b0) n_hs++;
            if (if_b.lcd_de === 1'b1) begin
                if (first_de < 0) begin
                    first_de = s; first_x = int'(if_b.lcd_x); first_y = int'(if_b.lcd_y);
                end
                last_de = s;
                last_x = int'(if_b.lcd_x);
                n_de++;
            end else if (if_b.lcd_x !== 12'd0 || if_b.lcd_y !== 12'd0) begin
                bad_zero++;
            end
        end
        n_cmp++; if (n_ls !== 36) begin n_bad++; $display("FAIL def_ls_count: got %0d want 36", n_ls); end
        n_cmp++; if (ls2 !== 800) begin n_bad++; $display("FAIL def_ls_period: got %0d want 800", ls2); end
        n_cmp++; if (n_fs !== 1) begin n_bad++; $display("FAIL def_fs_count: got %0d want 1", n_fs); end
        n_cmp++; if (n_hs !== 96) begin n_bad++; $display("FAIL def_hs_width: got %0d want 96", n_hs); end
        n_cmp++; if (n_de !== 640) begin n_bad++; $display("FAIL def_de_count: got %0d want 640", n_de); end
        n_cmp++; if (first_de !== 28144) begin n_bad++; $display("FAIL def_first_de: got %0d want 28144", first_de); end
        n_cmp++; if (first_x !== 0) begin n_bad++; $display("FAIL def_first_x: got %0d want 0", first_x); end
        n_cmp++; if (first_y !== 0) begin n_bad++; $display("FAIL def_first_y: got %0d want 0", first_y); end
        n_cmp++; if (last_de !== 28783) begin n_bad++; $display("FAIL def_last_de: got %0d want 28783", last_de); end
        n_cmp++; if (last_x !== 639) begin n_bad++; $display("FAIL def_last_x: got %0d want 639", last_x); end
        n_cmp++; if (bad_zero !== 0) begin n_bad++; $display("FAIL def_xy_zero: got %0d nonzero want 0", bad_zero); end
    endtask

`ifdef VGA_TILE_EN
    task automatic test_tile();
        bit found;
        rst_t = 1'b1;
        if_t.en = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_t.tile_col !== 12'd0) begin n_bad++; $display("FAIL tile_reset_col: got %0d want 0", if_t.tile_col); end
        n_cmp++; if (if_t.tile_px !== 5'd0) begin n_bad++; $display("FAIL tile_reset_px: got %0d want 0", if_t.tile_px); end
        rst_t = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (if_t.lcd_de === 1'b1 && if_t.lcd_x === 12'd70 && if_t.lcd_y === 12'd33) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL tile_reach: got %b want 1", found); end
        n_cmp++; if (if_t.tile_col !== 12'd2) begin n_bad++; $display("FAIL tile_col: got %0d want 2", if_t.tile_col); end
        n_cmp++; if (if_t.tile_px !== 5'd6) begin n_bad++; $display("FAIL tile_px: got %0d want 6", if_t.tile_px); end
        n_cmp++; if (if_t.tile_row !== 12'd1) begin n_bad++; $display("FAIL tile_row: got %0d want 1", if_t.tile_row); end
        n_cmp++; if (if_t.tile_py !== 5'd1) begin n_bad++; $display("FAIL tile_py: got %0d want 1", if_t.tile_py); end
    endtask
`endif

    initial begin
        if_a.en = 1'b0;
        if_b.en = 1'b0;
        if_c.en = 1'b0;
        if_d.en = 1'b0;
`ifdef VGA_TILE_EN
        if_t.en = 1'b0;
`endif
        test_reset();
        test_en_freeze();
        test_reset_mid();
        test_small_mode();
        test_polarity();
        test_default_mode();
`ifdef VGA_TILE_EN
        test_tile();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/LCD raster timing generator; successor to the fixed-mode drive block. Sits between the pixel clock domain and the Tetris renderer.
- Produces sync, data-enable, pixel coordinates and frame/line strobes for any mode set by parameters.
- Adds four things the fixed block lacks: sync polarity control, an internal pixel-clock divider with an external enable, start-of-line/frame strobes, and an exact inclusive active window.

Parameters:
- H_DISP, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISP, 480: active lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HS_POL, 0: active level of lcd_hs.
- VS_POL, 0: active level of lcd_vs.
- CLK_DIV, 2: clk cycles per pixel tick. Legal values are 1 to 16.
- CW, 12: width of the counter and coordinate buses.
- TILE_SHIFT, 5: log2 of the tile size. Used only with VGA_TILE_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-high (despite the name).
- en  in  1  run enable. When low, the divider and the counters freeze.
- pix_en  out  1  pixel tick. High for one clk every CLK_DIV clocks.
- lcd_hs  out  1  horizontal sync.
- lcd_vs  out  1  vertical sync.
- lcd_de  out  1  active-video data enable.
- lcd_x  out  CW  active pixel column. 0 outside the active window.
- lcd_y  out  CW  active line. 0 outside the active window.
- line_start  out  1  one-clk strobe marking the output of hcnt==0.
- frame_start  out  1  one-clk strobe marking the output of hcnt==0 and vcnt==0.
- tile_col, tile_row  out  CW  tile index (VGA_TILE_EN only).
- tile_px, tile_py  out  TILE_SHIFT  offset within the tile (VGA_TILE_EN only).

Behaviour:
- Interface: reset rst_n, asynchronous, active-high; clock clk.
- Constants:
  - H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT.
  - V_TOTAL is the same sum of the V_ parameters.
  - Region order within a line or frame: sync, back porch, active, front porch, starting at count 0.
- Reset values:
  - Divider = 0, hcnt = 0, vcnt = 0.
  - lcd_hs = ~HS_POL and lcd_vs = ~VS_POL (inactive).
  - lcd_de = 0, lcd_x = 0, lcd_y = 0, pix_en = 0, line_start = 0, frame_start = 0.
  - All tile outputs = 0.
- Divider:
  - Counts 0 to CLK_DIV-1 while en is high, then wraps.
  - pix_en is registered and is high on the clk after the divider reaches CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly high once en is high (first high one clk after en).
- Counters (advance only on clocks where pix_en=1):
  - hcnt counts 0 to H_TOTAL-1, then wraps to 0.
  - vcnt increments when hcnt wraps, and itself wraps at V_TOTAL-1.
  - Both wraps occur on the same tick at the end of a frame.
- Output register:
  - On every pix_en clock, all outputs load the decode of the pre-advance hcnt/vcnt. Outputs therefore lag the counters by exactly one pixel tick and stay mutually aligned and glitch-free.
  - Outputs hold between ticks. line_start and frame_start return to 0 on the next clk.
- Decode:
  - lcd_hs is at the active level when hcnt < H_SYNC.
  - lcd_vs is at the active level when vcnt < V_SYNC.
  - Active when hcnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] and vcnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1], both inclusive.
  - When active: lcd_de = 1, lcd_x = hcnt - (H_SYNC+H_BACK), lcd_y = vcnt - (V_SYNC+V_BACK).
  - When not active: lcd_de = 0, lcd_x = 0, lcd_y = 0.
- Arithmetic: all arithmetic is unsigned CW-bit. H_TOTAL and V_TOTAL must fit in CW bits; otherwise elaboration fails through a generate-time $error.
- en deasserted mid-frame: the divider, counters and output registers all hold; pix_en = 0. Resumption continues from the exact held position.
- Reset mid-frame: immediate return to the reset values. The first tick after release outputs the decode of (0,0): hs active, vs active, line_start = 1, frame_start = 1.

Optional Feature:
- Macro: VGA_TILE_EN.
- Defined:
  - tile_col = lcd_x >> TILE_SHIFT and tile_row = lcd_y >> TILE_SHIFT.
  - tile_px and tile_py are the low TILE_SHIFT bits of lcd_x and lcd_y.
  - These are registered in the same output stage, so they align with lcd_de. They are 0 when lcd_de = 0.
- Undefined: the tile ports and their logic are absent from the module.

Test Plan:
- Reset then release, with en=1 and CLK_DIV=2 -> pix_en every 2nd clk. First tick: lcd_hs=0, lcd_vs=0, frame_start=1 for exactly 1 clk. Second tick: frame_start=0.
- Small mode H_SYNC=2, H_BACK=1, H_DISP=4, H_FRONT=1 (H_TOTAL=8), with V_SYNC=1, V_BACK=1, V_DISP=3, V_FRONT=1 (V_TOTAL=6) and CLK_DIV=1 -> lcd_hs low for 2 of every 8 ticks. lcd_de high for 4 ticks per active line with lcd_x = 0,1,2,3. Three active lines, lcd_y = 0..2.
- Default 640x480 mode -> line_start every 800 ticks, frame_start every 420000 ticks. lcd_de count per frame = 307200. Last active pixel has x=639, y=479.
- HS_POL=1, VS_POL=1 -> syncs high during their sync regions and low in reset.
- en pulled low for 10 clks at hcnt=100 -> all outputs frozen, no pix_en. After release the next tick outputs the decode of hcnt=100.
- VGA_TILE_EN with TILE_SHIFT=5 at active x=70, y=33 -> tile_col=2, tile_px=6, tile_row=1, tile_py=1.
